// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush and saturating stats
module pipe_stage_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t state, state_nxt;
  logic main_v, skid_v, accept, load_main_in, load_main_skid, load_skid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  assign main_v    = state[1];
  assign skid_v    = state[0];
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign accept    = in_valid & in_ready;
  // occupancy register; reset drops every held beat immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  // next occupancy and register load selects; flush overrides every transition
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt    = accept ? ONE : EMPTY;
        load_main_in = accept;
      end
      ONE: begin
        state_nxt    = accept ? (out_ready ? ONE : FULL) : (out_ready ? EMPTY : ONE);
        load_main_in = accept & out_ready;
        load_skid    = accept & ~out_ready;
      end
      FULL: begin
        state_nxt      = out_ready ? ONE : FULL;
        load_main_skid = out_ready;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
  end
  // main and skid payload registers; a flush leaves a zeroed bubble behind
  always_ff @(posedge clk or posedge reset)
    if (reset || flush) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  // saturating statistics sampled from the pre-edge handshake; clear wins over increment
  always_ff @(posedge clk or posedge reset)
    if (reset || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= (main_v & ~out_ready & ~&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      bubble_cnt <= (~main_v & ~&bubble_cnt) ? bubble_cnt + 1'b1 : bubble_cnt;
      flush_cnt  <= (flush & (main_v | skid_v) & ~&flush_cnt) ? flush_cnt + 1'b1 : flush_cnt;
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and randomized checks of pipe_stage_skid against a queue model
module tb_pipe_stage_skid;
  localparam int DW = 128;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic in_ready, out_valid, in_ready3, out_valid3;
  logic [DW-1:0] out_data, out_data3;
  logic [CW-1:0] out_ctrl, out_ctrl3;
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [2:0] stall3, bubble3, flush3;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pipe_stage_skid dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .cnt_clr(cnt_clr),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );
  pipe_stage_skid #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid3),
    .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3), .cnt_clr(cnt_clr),
    .stall_cnt(stall3), .bubble_cnt(bubble3), .flush_cnt(flush3)
  );
  // reference: a 2-deep FIFO of {ctrl,data}; shown is what the output register holds
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] shown = '0;
  int m_stall = 0, m_bubble = 0, m_flush = 0;
  bit m_ov, m_ir;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      shown = '0;
      m_stall = 0;
      m_bubble = 0;
      m_flush = 0;
    end else begin
      m_ov = q.size() > 0;
      m_ir = q.size() < 2;
      if (cnt_clr) begin
        m_stall = 0;
        m_bubble = 0;
        m_flush = 0;
      end else begin
        m_stall += int'(m_ov && !out_ready);
        m_bubble += int'(!m_ov);
        m_flush += int'(flush && m_ov);
      end
      if (flush) begin
        q.delete();
        shown = '0;
      end else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) q.push_back({in_ctrl, in_data});
        if (q.size() > 0) shown = q[0];
      end
    end
  end
  function automatic int sat(int v, int mx);
    return v > mx ? mx : v;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = DW'(5);
    out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
    checks++; if (out_ctrl !== '0) begin errs++; $display("FAIL reset_out_ctrl: got %0h want 0", out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin errs++; $display("FAIL reset_counters: got %0h/%0h/%0h want 0", stall_cnt, bubble_cnt, flush_cnt); end
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== DW'(5)) begin errs++; $display("FAIL first_accept: got v=%0b d=%0h want v=1 d=5", out_valid, out_data); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL first_drain: got %0b want 0", out_valid); end
  endtask
  task automatic test_stream;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin errs++; $display("FAIL stream_beat%0d: got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i); end
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready%0d: got %0b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL stream_stall: got %0d want 0", stall_cnt); end
  endtask
  task automatic test_backpressure;
    logic [15:0] s0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = DW'(10);
    step();
    checks++; if (out_data !== DW'(10)) begin errs++; $display("FAIL bp_first: got %0h want a", out_data); end
    s0 = stall_cnt;
    in_data = DW'(11);
    out_ready = 1'b0;
    step();
    checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    in_data = DW'(12);
    for (int i = 1; i <= 3; i++) begin
      checks++; if (out_data !== DW'(10) || out_valid !== 1'b1) begin errs++; $display("FAIL bp_hold%0d: got v=%0b d=%0h want v=1 d=a", i, out_valid, out_data); end
      checks++; if (stall_cnt !== s0 + 16'(i)) begin errs++; $display("FAIL bp_stall%0d: got %0d want %0d", i, stall_cnt, s0 + 16'(i)); end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== DW'(11) || in_ready !== 1'b1) begin errs++; $display("FAIL bp_drain11: got d=%0h r=%0b want d=b r=1", out_data, in_ready); end
    step();
    checks++; if (out_data !== DW'(12) || out_valid !== 1'b1) begin errs++; $display("FAIL bp_drain12: got v=%0b d=%0h want v=1 d=c", out_valid, out_data); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
  endtask
  task automatic test_flush;
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_ctrl = 16'hFFFF;
    in_data = DW'(20);
    step();
    in_data = DW'(21);
    step();
    checks++; if (in_ready !== 1'b0 || out_ctrl !== 16'hFFFF) begin errs++; $display("FAIL flush_pre_full: got r=%0b c=%0h want r=0 c=ffff", in_ready, out_ctrl); end
    flush = 1'b1;
    in_data = DW'(22);
    step();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin errs++; $display("FAIL flush_bubble: got v=%0b c=%0h d=%0h want 0/0/0", out_valid, out_ctrl, out_data); end
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    checks++; if (flush_cnt !== 16'd1) begin errs++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
    in_valid = 1'b0;
    step();
    checks++; if (flush_cnt !== 16'd1 || out_valid !== 1'b0) begin errs++; $display("FAIL flush_empty: got cnt=%0d v=%0b want 1/0", flush_cnt, out_valid); end
    flush = 1'b0;
    in_ctrl = '0;
  endtask
  task automatic test_saturate;
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    repeat (12) step();
    checks++; if (bubble3 !== 3'd7) begin errs++; $display("FAIL sat_bubble3: got %0d want 7", bubble3); end
    checks++; if (bubble_cnt !== 16'd12) begin errs++; $display("FAIL sat_bubble16: got %0d want 12", bubble_cnt); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++; if (bubble3 !== 3'd0 || bubble_cnt !== 16'd0) begin errs++; $display("FAIL clr_priority: got %0d/%0d want 0/0", bubble3, bubble_cnt); end
  endtask
  task automatic test_async_reset;
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data = DW'(30);
    step();
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL areset_pre: got v=%0b r=%0b want 1/0", out_valid, in_ready); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin errs++; $display("FAIL areset_immediate: got v=%0b r=%0b d=%0h want 0/1/0", out_valid, in_ready, out_data); end
    reset = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL areset_after: got %0b want 0", out_valid); end
  endtask
  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 19) == 0);
      cnt_clr = 1'($urandom_range(0, 49) == 0);
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_ctrl = CW'($urandom());
      step();
      checks++; if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin errs++; $display("FAIL rnd_hs@%0d: got v=%0b r=%0b want v=%0b r=%0b", n, out_valid, in_ready, q.size() > 0, q.size() < 2); end
      checks++; if ({out_ctrl, out_data} !== shown) begin errs++; $display("FAIL rnd_payload@%0d: got %0h want %0h", n, {out_ctrl, out_data}, shown); end
      checks++; if (int'(stall_cnt) != sat(m_stall, 65535) || int'(bubble_cnt) != sat(m_bubble, 65535) || int'(flush_cnt) != sat(m_flush, 65535)) begin errs++; $display("FAIL rnd_cnt@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, stall_cnt, bubble_cnt, flush_cnt, m_stall, m_bubble, m_flush); end
      checks++; if (int'(stall3) != sat(m_stall, 7) || int'(bubble3) != sat(m_bubble, 7) || int'(flush3) != sat(m_flush, 7)) begin errs++; $display("FAIL rnd_cnt3@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, stall3, bubble3, flush3, sat(m_stall, 7), sat(m_bubble, 7), sat(m_flush, 7)); end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
